// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Returns {remainder, quotient}. A registered start/ready handshake is used,
// and annul_i cancels a divide that is in flight.
// Optional feature: define DIV_ZERO_FLAG_EN to add the div_zero_o output,
// which reports a zero divisor while the result is presented.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
`ifdef DIV_ZERO_FLAG_EN
  output logic               div_zero_o,
`endif
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;      // partial remainder
  logic [WIDTH-1:0]   dvd_q, dvd_d;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;    // divisor magnitude
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic               zero_q, zero_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  // Magnitudes of the incoming operands. The most negative value maps to
  // itself, which then reads correctly as an unsigned magnitude.
  logic [WIDTH-1:0] abs1, abs2;
  // One restoring step: compare/subtract is WIDTH+1 bits wide so the shifted
  // partial remainder never overflows.
  logic [WIDTH:0]   shifted, diff;
  logic             ge;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  // Datapath helpers: operand magnitudes, one division step and sign fix-up
  always_comb begin
    abs1     = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    abs2     = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    ge       = (shifted >= {1'b0, dvsr_q});
    diff     = shifted - {1'b0, dvsr_q};
    quot_fix = neg_quot_q ? -dvd_q : dvd_q;
    rem_fix  = neg_rem_q ? -rem_q : rem_q;
  end

  // Next-state logic for the controller and the iteration registers
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dvsr_d     = dvsr_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    zero_d     = zero_q;
    result_d   = result_q;
    case (state_q)
      S_FREE: begin
        if (start_i && !annul_i) begin
          dvd_d      = abs1;
          dvsr_d     = abs2;
          neg_quot_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          neg_rem_d  = signed_div_i && opdata1_i[WIDTH-1];
          zero_d     = (opdata2_i == '0);
          cnt_d      = '0;
          rem_d      = '0;
          state_d    = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          state_d = S_FREE;
        end else begin
          state_d  = S_END;
          result_d = '0;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_FREE;
        end else if (cnt_q == CW'(WIDTH)) begin
          state_d  = S_END;
          result_d = {rem_fix, quot_fix};
        end else begin
          rem_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], ge};
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_END: begin
        // Holding start_i keeps the result presented; it never restarts.
        if (annul_i || !start_i) begin
          state_d = S_FREE;
        end
      end
      default: state_d = S_FREE;
    endcase
    // ready_o rises one cycle after END is entered and drops on the edge
    // that leaves END.
    ready_d = (state_q == S_END) && (state_d == S_END);
  end

  // All controller and datapath state; reset wins over every input
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FREE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvsr_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_q     <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dvsr_q     <= dvsr_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      zero_q     <= zero_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  logic div_zero_q, div_zero_d;

  // Zero-divisor flag, high while in END for a divide by zero
  always_comb begin
    div_zero_d = (state_d == S_END) && zero_d;
  end

  // Flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      div_zero_q <= 1'b0;
    end else begin
      div_zero_q <= div_zero_d;
    end
  end

  assign div_zero_o = div_zero_q;
`endif

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against a
// plain-arithmetic reference model.
module tb_div_unit;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic           annul_i;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
`ifdef DIV_ZERO_FLAG_EN
  logic           div_zero_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
`ifdef DIV_ZERO_FLAG_EN
    .div_zero_o   (div_zero_o),
`endif
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  // Reference: {remainder, quotient} from ordinary integer division.
  function automatic logic [2*W-1:0] ref_div(input logic sgn, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return '0;
    if (!sgn) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;   // truncates toward zero; remainder follows dividend sign
    r  = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // One complete divide: request, measure latency, check result and release.
  task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input string tag);
    int  lat;
    bit  seen;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);            // accepting edge, cycle 0
    #1;
    opdata1_i    = $urandom;   // must be ignored from here on
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom_range(0, 1));
    lat  = 0;
    seen = 0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (ready_o) begin
        seen = 1;
        lat  = c;
      end
    end
    chk({tag, " latency"}, 64'(lat), (b == '0) ? 64'd2 : 64'(W + 2));
    chk({tag, " result"}, result_o, exp);
`ifdef DIV_ZERO_FLAG_EN
    chk({tag, " div_zero"}, 64'(div_zero_o), 64'(b == '0));
`endif
    $display("op %s sgn=%0d a=%h b=%h -> lat=%0d result=%h", tag, sgn, a, b, lat, result_o);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " ready drop"}, 64'(ready_o), 64'd0);
    chk({tag, " result hold"}, result_o, exp);
  endtask

  initial begin
    logic [2*W-1:0] prev;
    logic           sgn;
    logic [W-1:0]   a, b;
    int             rises, highs;
    logic           last;

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases with hand-computed expectations
    run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, "divu_100_7");
    run_op(1'b1, -32'sd7, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_m7_2");
    run_op(1'b1, 32'd7, -32'sd2, {32'd1, 32'hFFFF_FFFD}, "div_7_m2");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, "div_min_m1");
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, "divu_min_max");
    run_op(1'b1, 32'd123, 32'd0, 64'd0, "div_by_zero");
    run_op(1'b0, 32'd55, 32'd5, {32'd0, 32'd11}, "divu_55_5");

    // Annul after 10 cycles of iteration: no result, old result kept
    prev = result_o;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd6; start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("annul ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    highs = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (ready_o) highs++;
    end
    chk("annul no ready", 64'(highs), 64'd0);
    chk("annul result kept", result_o, prev);
    $display("op annul -> ready highs=%0d result=%h", highs, result_o);
    run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, "divu_9_3");

    // Reset mid-operation clears ready and result
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("midop rst ready", 64'(ready_o), 64'd0);
    chk("midop rst result", result_o, 64'd0);
    $display("op midop_rst -> ready=%0d result=%h", ready_o, result_o);
    @(negedge clk);
    rst = 1'b0;

    // start_i held for 40 cycles after completion: one result, END held
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd10; start_i = 1'b1;
    rises = 0; last = 1'b0;
    for (int c = 0; c < W + 2 + 40; c++) begin
      @(posedge clk);
      #1;
      if (ready_o && !last) rises++;
      last = ready_o;
    end
    chk("held rises", 64'(rises), 64'd1);
    chk("held ready", 64'(ready_o), 64'd1);
    chk("held result", result_o, {32'd0, 32'd100});
    $display("op held -> rises=%0d ready=%0d result=%h", rises, ready_o, result_o);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("held release", 64'(ready_o), 64'd0);

    // Randomized operands against the reference model
    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = -W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(sgn, a, b, ref_div(sgn, a, b), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
